// File: rtl/mm_pkg.sv
// Shared types and constants for the memory-matrix game core.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        SHOW,
        PLAY,
        CHECK,
        WIN,
        LOSE
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          TIMEOUT_MULT      = 4;

    // States in which the status LED flashes and the flash divider runs.
    function automatic logic is_flash_state(input state_t s);
        return (s == IDLE) || (s == WIN) || (s == LOSE);
    endfunction

endpackage

// File: rtl/mm_tick_counter.sv
// Down-counter that reloads PERIOD-1 and emits a one-cycle tick at terminal count.
module mm_tick_counter #(
    parameter int PERIOD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LOAD = W'(PERIOD - 1);

    logic [W-1:0] count;

    assign tick = enable && !clear && (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable) begin
            if (count == '0) begin
                count <= LOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_matrix_core.sv
// Memory-matrix game core: pattern generation, display, guess tracking, win/lose flashing.
// Optional PLAY inactivity timeout is enabled by defining MM_TIMEOUT_EN.
module memory_matrix_core
    import mm_pkg::*;
#(
    parameter int TILES          = 9,
    parameter int GUESS_W        = 4,
    parameter int DISPLAY_CYCLES = 50000000,
    parameter int FLASH_CYCLES   = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [GUESS_W-1:0] guesses_in,
    input  logic [15:0]        seed,
    input  logic               board_ld,
    input  logic [TILES-1:0]   board_in,
    input  logic [TILES-1:0]   tile_press,
    output logic [TILES-1:0]   board_led,
    output logic               status_led,
    output logic [GUESS_W-1:0] guesses_left,
    output logic               win,
    output logic               lose
);

    state_t             state, state_next;
    logic [15:0]        lfsr;
    logic [TILES-1:0]   solution, found, guess, press_q, press;
    logic [TILES-1:0]   candidate, found_merge;
    logic               start_q, start_rise, ld_q, forced_wrong, correct;
    logic [GUESS_W-1:0] gl;
    logic               flash_phase, flash_tick, flash_clear, flash_en;
    logic               show_tick, timeout_tick;

    assign start_rise   = start & ~start_q;
    assign press        = tile_press & ~press_q;
    assign guesses_left = gl;

    // The flash divider restarts whenever a flashing state is entered.
    assign flash_en    = is_flash_state(state);
    assign flash_clear = !flash_en || (state_next != state);

    mm_tick_counter #(.PERIOD(DISPLAY_CYCLES)) u_show_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != SHOW),
        .enable (state == SHOW),
        .tick   (show_tick)
    );

    mm_tick_counter #(.PERIOD(FLASH_CYCLES)) u_flash_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (flash_clear),
        .enable (flash_en),
        .tick   (flash_tick)
    );

`ifdef MM_TIMEOUT_EN
    mm_tick_counter #(.PERIOD(TIMEOUT_MULT * DISPLAY_CYCLES)) u_play_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != PLAY),
        .enable (state == PLAY),
        .tick   (timeout_tick)
    );
`else
    assign timeout_tick = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        candidate   = ld_q ? board_in : lfsr[TILES-1:0];
        correct     = ((guess & ~solution) == '0) && !forced_wrong;
        found_merge = correct ? (found | guess) : found;
        case (state)
            IDLE:  if (start_rise && (guesses_in != '0)) state_next = GEN;
            GEN: begin
                if (candidate == '0) begin
                    state_next = ld_q ? IDLE : GEN;
                end else begin
                    state_next = SHOW;
                end
            end
            SHOW:  if (show_tick) state_next = PLAY;
            PLAY:  if ((press != '0) || timeout_tick) state_next = CHECK;
            CHECK: begin
                if (found_merge == solution) begin
                    state_next = WIN;
                end else if (!correct && (gl == GUESS_W'(1))) begin
                    state_next = LOSE;
                end else begin
                    state_next = PLAY;
                end
            end
            WIN, LOSE: if (start_rise) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            lfsr         <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
            solution     <= '0;
            found        <= '0;
            guess        <= '0;
            press_q      <= '0;
            start_q      <= 1'b0;
            ld_q         <= 1'b0;
            forced_wrong <= 1'b0;
            gl           <= '0;
        end else begin
            state   <= state_next;
            lfsr    <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            start_q <= start;
            press_q <= tile_press;
            case (state)
                IDLE: begin
                    if (state_next == GEN) begin
                        gl   <= guesses_in;
                        ld_q <= board_ld;
                    end
                end
                GEN: begin
                    solution <= candidate;
                    found    <= '0;
                end
                PLAY: begin
                    if (press != '0) begin
                        guess        <= press;
                        forced_wrong <= 1'b0;
                    end else if (timeout_tick) begin
                        guess        <= '0;
                        forced_wrong <= 1'b1;
                    end
                end
                CHECK: begin
                    if (correct) begin
                        found <= found_merge;
                    end else if (gl != '0) begin
                        gl <= gl - GUESS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs follow the current state, so they trail a state change by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flash_phase <= 1'b0;
            board_led   <= '0;
            status_led  <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            if (flash_clear) begin
                flash_phase <= 1'b0;
            end else if (flash_tick) begin
                flash_phase <= ~flash_phase;
            end
            board_led  <= '0;
            status_led <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            case (state)
                IDLE:        status_led <= flash_phase;
                SHOW:        board_led  <= solution;
                PLAY, CHECK: board_led  <= found;
                WIN: begin
                    win        <= 1'b1;
                    status_led <= flash_phase;
                    board_led  <= flash_phase ? '1 : '0;
                end
                LOSE: begin
                    lose       <= 1'b1;
                    status_led <= flash_phase;
                    board_led  <= flash_phase ? solution : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_matrix_core.sv
// Directed, table-driven bench for memory_matrix_core (TILES=9, short display/flash periods).
module tb_memory_matrix_core;

    localparam int TILES          = 9;
    localparam int GUESS_W        = 4;
    localparam int DISPLAY_CYCLES = 8;
    localparam int FLASH_CYCLES   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [GUESS_W-1:0] guesses_in = '0;
    logic [15:0]        seed = '0;
    logic               board_ld = 1'b0;
    logic [TILES-1:0]   board_in = '0;
    logic [TILES-1:0]   tile_press = '0;
    logic [TILES-1:0]   board_led;
    logic               status_led;
    logic [GUESS_W-1:0] guesses_left;
    logic               win;
    logic               lose;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [TILES-1:0]   press;
        logic [TILES-1:0]   exp_board;
        logic [GUESS_W-1:0] exp_gl;
        logic               exp_win;
        logic               exp_lose;
    } vec_t;

    vec_t vecs [9];

    memory_matrix_core #(
        .TILES          (TILES),
        .GUESS_W        (GUESS_W),
        .DISPLAY_CYCLES (DISPLAY_CYCLES),
        .FLASH_CYCLES   (FLASH_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .guesses_in   (guesses_in),
        .seed         (seed),
        .board_ld     (board_ld),
        .board_in     (board_in),
        .tile_press   (tile_press),
        .board_led    (board_led),
        .status_led   (status_led),
        .guesses_left (guesses_left),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One press of a table vector: hold, release, settle, then compare.
    task automatic applyStimulus(input int idx);
        tile_press = vecs[idx].press;
        tick();
        tick();
        tile_press = '0;
        tick();
        tick();
        checkOutput($sformatf("vec%0d_board", idx), 16'(board_led), 16'(vecs[idx].exp_board));
        checkOutput($sformatf("vec%0d_guesses", idx), 16'(guesses_left), 16'(vecs[idx].exp_gl));
        checkOutput($sformatf("vec%0d_win", idx), 16'(win), 16'(vecs[idx].exp_win));
        checkOutput($sformatf("vec%0d_lose", idx), 16'(lose), 16'(vecs[idx].exp_lose));
    endtask

    task automatic startGame(input logic [GUESS_W-1:0] g, input logic ld, input logic [TILES-1:0] pat);
        start = 1'b0;
        tick();
        guesses_in = g;
        board_ld   = ld;
        board_in   = pat;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic returnIdle();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic waitFor(input logic [TILES-1:0] val, input int limit);
        for (int c = 0; c < limit; c++) begin
            if (board_led === val) break;
            tick();
        end
    endtask

    task automatic measureRun(input logic [TILES-1:0] val, output int len);
        len = 0;
        for (int c = 0; c < 16; c++) begin
            if (board_led !== val) break;
            len++;
            tick();
        end
    endtask

    initial begin
        int run;
        int len;
        logic seen;

        vecs[0] = '{9'h001, 9'h001, 4'd3, 1'b0, 1'b0};
        vecs[1] = '{9'h004, 9'h005, 4'd3, 1'b0, 1'b0};
        vecs[2] = '{9'h020, 9'h025, 4'd3, 1'b0, 1'b0};
        vecs[3] = '{9'h080, 9'h000, 4'd3, 1'b1, 1'b0};
        vecs[4] = '{9'h002, 9'h000, 4'd1, 1'b0, 1'b0};
        vecs[5] = '{9'h002, 9'h000, 4'd0, 1'b0, 1'b1};
        vecs[6] = '{9'h001, 9'h001, 4'd3, 1'b0, 1'b0};
        vecs[7] = '{9'h003, 9'h001, 4'd2, 1'b0, 1'b0};
        vecs[8] = '{9'h001, 9'h001, 4'd2, 1'b0, 1'b0};

        // Reset state.
        reset = 1'b0;
        seed  = 16'h0000;
        repeat (3) tick();
        checkOutput("rst_board", 16'(board_led), 16'h0);
        checkOutput("rst_status", 16'(status_led), 16'h0);
        checkOutput("rst_guesses", 16'(guesses_left), 16'h0);
        checkOutput("rst_win", 16'(win), 16'h0);
        checkOutput("rst_lose", 16'(lose), 16'h0);

        // Start with zero budget is ignored; status LED flashes with period 2*FLASH_CYCLES.
        reset      = 1'b1;
        start      = 1'b1;
        guesses_in = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checkOutput($sformatf("idle_flash%0d", k), 16'(status_led), 16'(((k - 1) / 4) % 2));
        end
        checkOutput("idle_guesses", 16'(guesses_left), 16'h0);
        checkOutput("idle_board", 16'(board_led), 16'h0);

        // Game 1: fixed puzzle, SHOW length, press during SHOW discarded, then win.
        startGame(4'd3, 1'b1, 9'h0A5);
        waitFor(9'h0A5, 10);
        checkOutput("show_start", 16'(board_led), 16'h0A5);
        run = 0;
        for (int c = 0; c < 20; c++) begin
            if (board_led !== 9'h0A5) break;
            run++;
            if (run == 3) tile_press = 9'h002;
            if (run == 5) tile_press = '0;
            tick();
        end
        checkOutput("show_len", 16'(run), 16'd8);
        checkOutput("show_end", 16'(board_led), 16'h0);
        checkOutput("show_guesses", 16'(guesses_left), 16'd3);
        for (int i = 0; i <= 3; i++) applyStimulus(i);
        waitFor(9'h1FF, 12);
        checkOutput("win_on", 16'(board_led), 16'h1FF);
        checkOutput("win_status", 16'(status_led), 16'h1);
        measureRun(9'h1FF, len);
        checkOutput("win_on_len", 16'(len), 16'd4);
        measureRun(9'h000, len);
        checkOutput("win_off_len", 16'(len), 16'd4);
        returnIdle();
        checkOutput("win_exit", 16'(win), 16'h0);
        checkOutput("win_exit_board", 16'(board_led), 16'h0);

        // Game 2: two wrong guesses exhaust the budget.
        startGame(4'd2, 1'b1, 9'h0A5);
        repeat (11) tick();
        for (int i = 4; i <= 5; i++) applyStimulus(i);
        waitFor(9'h0A5, 12);
        checkOutput("lose_on", 16'(board_led), 16'h0A5);
        checkOutput("lose_flag", 16'(lose), 16'h1);
        measureRun(9'h0A5, len);
        checkOutput("lose_on_len", 16'(len), 16'd4);
        returnIdle();
        checkOutput("lose_exit", 16'(lose), 16'h0);

        // Game 3: simultaneous press, re-press of found tile, then reset mid-game.
        startGame(4'd3, 1'b1, 9'h0A5);
        repeat (11) tick();
        for (int i = 6; i <= 8; i++) applyStimulus(i);
        reset = 1'b0;
        tick();
        checkOutput("midrst_board", 16'(board_led), 16'h0);
        checkOutput("midrst_guesses", 16'(guesses_left), 16'h0);
        checkOutput("midrst_status", 16'(status_led), 16'h0);
        checkOutput("midrst_win", 16'(win), 16'h0);
        checkOutput("midrst_lose", 16'(lose), 16'h0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("postrst_board", 16'(board_led), 16'h0);
        checkOutput("postrst_guesses", 16'(guesses_left), 16'h0);

        // LFSR-generated puzzle must show a non-empty pattern.
        startGame(4'd1, 1'b0, 9'h000);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (board_led !== '0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("lfsr_show", 16'(seen), 16'h1);

`ifdef MM_TIMEOUT_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        startGame(4'd3, 1'b1, 9'h0A5);
        repeat (47) tick();
        checkOutput("timeout_guesses", 16'(guesses_left), 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
